pulse_stretch: RTL and testbench

Converts single-cycle strobes (as produced by the team's one-shot edge detectors) back into a clean level: each accepted strobe drives `Level` high for exactly `HOLD_CYCLES` cycles, followed by a guaranteed low gap. Strobes arriving while a level is in progress are queued in a saturating pending counter and replayed back-to-back. It sits between control FSMs emitting one-cycle `Shot` events and consumers that need a minimum-width level, such as LEDs, handshake partners or a slower domain.

---
 rtl/pulse_stretch_pkg.sv | 28 ++
 rtl/pulse_stretch_if.sv | 19 +
 rtl/pulse_stretch_sat_counter.sv | 51 +++++
 rtl/pulse_stretch.sv | 156 +++++++++++++++
 tb/tb_pulse_stretch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg
//   Shared types and width helpers for the pulse stretcher.
//   Exports:
//     pulse_stretch_state_t : FSM state encoding (PS_IDLE, PS_HOLD, PS_GAP)
//     ps_cnt_width()        : width of the hold/gap down-counter
//     ps_pend_width()       : width of the pending-strobe counter
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_HOLD = 2'd1,
    PS_GAP  = 2'd2
  } pulse_stretch_state_t;

  // The counter is loaded with N-1, so $clog2(N) bits are enough; never below 1 bit.
  function automatic int unsigned ps_cnt_width(input int unsigned hold_cycles,
                                               input int unsigned gap_cycles);
    int unsigned m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  // The pending counter must represent 0..pend_max inclusive.
  function automatic int unsigned ps_pend_width(input int unsigned pend_max);
    return (pend_max < 1) ? 1 : $clog2(pend_max + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if
//   Strobe-in / level-out bundle for the pulse stretcher.
//   Shot, Clear         : driven by the master (control FSM side)
//   Level, Busy, Done,
//   Overflow            : driven by the slave (pulse_stretch)
interface pulse_stretch_if;
  logic Shot;
  logic Clear;
  logic Level;
  logic Busy;
  logic Done;
  logic Overflow;

  modport master (output Shot, output Clear,
                  input  Level, input Busy, input Done, input Overflow);

  modport slave  (input  Shot, input Clear,
                  output Level, output Busy, output Done, output Overflow);
endinterface

// File: rtl/pulse_stretch_sat_counter.sv
// sat_counter
//   Saturating up/down counter holding the number of queued strobes.
//   Ports:
//     clk, reset : clock, asynchronous active-low reset
//     inc, dec   : count up / down; both together leave the count unchanged
//     clr        : synchronous clear, wins over inc/dec
//     count      : current count (0..MAX)
//     nonzero    : count != 0
//     full       : count == MAX
//     overflow   : an increment was refused because the counter is full
module sat_counter
  import pulse_stretch_pkg::*;
#(
  parameter  int unsigned MAX = 3,
  localparam int unsigned W   = ps_pend_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         full,
  output logic         overflow
);

  logic [W-1:0] count_q, count_d;

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign full     = (count_q == W'(MAX));
  assign overflow = inc & full & ~dec;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (!full) count_d = count_q + W'(1);
    end else if (dec && !inc) begin
      if (nonzero) count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch
//   Stretches one-cycle Shot strobes into Level pulses of HOLD_CYCLES cycles,
//   separated by at least GAP_CYCLES low cycles. Strobes arriving while a
//   level is active are queued (up to PEND_MAX) and replayed back-to-back.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset
//     ps    : pulse_stretch_if.slave (Shot, Clear in; Level, Busy, Done, Overflow out)
//   Build option:
//     PULSE_STRETCH_RETRIGGER_EN : when defined, Shot during a hold restarts
//                                  the hold instead of queuing.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   PS_IDLE | no level in progress, queue empty
//   PS_HOLD | Level high, counter counts down the hold time
//   PS_GAP  | Level low, counter counts down the forced gap
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned PEND_MAX    = 3
) (
  input logic          clk,
  input logic          reset,
  pulse_stretch_if.slave ps
);

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam int unsigned CNT_W  = ps_cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned PEND_W = ps_pend_width(PEND_MAX);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  pulse_stretch_state_t state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic                 inc, dec;
  logic [PEND_W-1:0]    pend_count;
  logic                 pend_nonzero, pend_full, pend_ovf;

  sat_counter #(.MAX(PEND_MAX)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .dec      (dec),
    .clr      (ps.Clear),
    .count    (pend_count),
    .nonzero  (pend_nonzero),
    .full     (pend_full),
    .overflow (pend_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    dec     = 1'b0;

    case (state_q)
      PS_IDLE: begin
        if (ps.Shot) begin
          state_d = PS_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      PS_HOLD: begin
        if (RETRIG && ps.Shot) begin
          cnt_d = HOLD_LOAD;
        end else begin
          inc = ps.Shot;
          if (cnt_q == '0) begin
            state_d = PS_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      PS_GAP: begin
        if (cnt_q != '0) begin
          inc   = ps.Shot;
          cnt_d = cnt_q - CNT_ONE;
        end else if (pend_nonzero || ps.Shot) begin
          // Final gap cycle: a fresh Shot with an empty queue starts the hold
          // directly; with a non-empty queue it replaces the consumed entry.
          state_d = PS_HOLD;
          cnt_d   = HOLD_LOAD;
          dec     = pend_nonzero;
          inc     = ps.Shot & pend_nonzero;
        end else begin
          state_d = PS_IDLE;
        end
      end

      default: begin
        state_d = PS_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (ps.Clear) begin
      state_d = PS_IDLE;
      cnt_d   = '0;
      inc     = 1'b0;
      dec     = 1'b0;
    end
  end

  assign level_d = (state_d == PS_HOLD);
  assign done_d  = !ps.Clear && (state_q == PS_HOLD) && (state_d == PS_GAP);
  assign busy_d  = !ps.Clear && ((state_d != PS_IDLE) || (pend_count != '0));
  assign ovf_d   = !ps.Clear && (ovf_q || pend_ovf);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ps.Level    = level_q;
  assign ps.Busy     = busy_q;
  assign ps.Done     = done_q;
  assign ps.Overflow = ovf_q;

  // The queue can only fill up while a level sequence is running.
  a_full_implies_active: assert property (@(posedge clk) disable iff (!reset)
    pend_full |-> (state_q != PS_IDLE));

endmodule

// File: tb/tb_pulse_stretch.sv
module tb_pulse_stretch;

  localparam int H = 8;
  localparam int G = 1;
  localparam int P = 3;
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  pulse_stretch_if ps();

  pulse_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(P)) dut (
    .clk   (clk),
    .reset (reset),
    .ps    (ps)
  );

  always #5 clk = ~clk;

  // Model: a level that started from cycle c is high through hold_end = c+H;
  // the final gap cycle is hold_end+G.
  typedef struct {
    bit active;
    int hold_end;
    int pend;
    bit ovf;
  } mstate_t;

  mstate_t m;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rec_base = 0;
  bit rec_en = 1'b0;
  logic [5:0] ri;
  logic [63:0] lvl_v, done_v, busy_v, ovf_v;
  logic [63:0] mlvl_v, mdone_v, mbusy_v, movf_v;
  logic e_level, e_done, e_busy, e_ovf;

  function automatic mstate_t m_next(input mstate_t s, input int c, input bit shot, input bit clr);
    mstate_t n;
    n = s;
    if (clr) begin
      n.active = 1'b0;
      n.pend   = 0;
      n.ovf    = 1'b0;
    end else if (!s.active) begin
      if (shot) begin
        n.active   = 1'b1;
        n.hold_end = c + H;
      end
    end else if (c == s.hold_end + G) begin
      if (s.pend > 0 || shot) begin
        n.hold_end = c + H;
        if (!shot) n.pend = s.pend - 1;
      end else begin
        n.active = 1'b0;
      end
    end else if (shot) begin
      if (RETRIG && c <= s.hold_end) n.hold_end = c + H;
      else if (s.pend == P)          n.ovf = 1'b1;
      else                           n.pend = s.pend + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '{active: 1'b0, hold_end: 0, pend: 0, ovf: 1'b0};
    else        m <= m_next(m, cyc, ps.Shot, ps.Clear);
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign e_level = m.active && (cyc <= m.hold_end);
  assign e_done  = m.active && (cyc == m.hold_end + 1);
  assign e_busy  = m.active;
  assign e_ovf   = m.ovf;
  assign ri      = 6'(cyc - rec_base);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    check("level", 64'(ps.Level),    64'(e_level));
    check("done",  64'(ps.Done),     64'(e_done));
    check("busy",  64'(ps.Busy),     64'(e_busy));
    check("ovf",   64'(ps.Overflow), 64'(e_ovf));
    if (rec_en) begin
      if (cyc == rec_base) begin
        lvl_v   <= 64'(ps.Level);
        done_v  <= 64'(ps.Done);
        busy_v  <= 64'(ps.Busy);
        ovf_v   <= 64'(ps.Overflow);
        mlvl_v  <= 64'(e_level);
        mdone_v <= 64'(e_done);
        mbusy_v <= 64'(e_busy);
        movf_v  <= 64'(e_ovf);
      end else begin
        lvl_v[ri]   <= ps.Level;
        done_v[ri]  <= ps.Done;
        busy_v[ri]  <= ps.Busy;
        ovf_v[ri]   <= ps.Overflow;
        mlvl_v[ri]  <= e_level;
        mdone_v[ri] <= e_done;
        mbusy_v[ri] <= e_busy;
        movf_v[ri]  <= e_ovf;
      end
    end
  end

  // Called at posedge+2: inputs hold for the current cycle, returns one cycle later.
  task automatic cycle_in(input bit shot, input bit clr);
    ps.Shot  = shot;
    ps.Clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    cycle_in(1'b0, 1'b1);
    repeat (3) cycle_in(1'b0, 1'b0);
  endtask

  task automatic run_rec(input logic [63:0] shots, input logic [63:0] clrs, input int len);
    rec_base = cyc;
    rec_en   = 1'b1;
    for (int i = 0; i < len; i++) cycle_in(shots[i], clrs[i]);
    rec_en   = 1'b0;
    ps.Shot  = 1'b0;
    ps.Clear = 1'b0;
  endtask

  task automatic verify(input string name, input logic [63:0] exp_l,
                        input logic [63:0] exp_d, input logic [63:0] exp_b);
    check({name, "_level"},       lvl_v,   exp_l);
    check({name, "_done"},        done_v,  exp_d);
    check({name, "_busy"},        busy_v,  exp_b);
    check({name, "_model_level"}, mlvl_v,  exp_l);
    check({name, "_model_done"},  mdone_v, exp_d);
    check({name, "_model_busy"},  mbusy_v, exp_b);
  endtask

  initial begin
    int dens;
    reset    = 1'b0;
    ps.Shot  = 1'b0;
    ps.Clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 64'({ps.Level, ps.Busy, ps.Done, ps.Overflow}), 64'h0);
    reset = 1'b1;

    // Single strobe: Level 1..8, Done 9, Busy low from 10.
    run_rec(64'h1, 64'h0, 16);
    verify("single", 64'h1FE, 64'h200, 64'h3FE);
    settle();

    // Queued strobes at 0, 2, 4.
    run_rec(64'h15, 64'h0, 30);
    verify("queued", 64'h07FB_FDFE, 64'h0804_0200, 64'h0FFF_FFFE);
    settle();

    // Overflow: strobes 0..4, the fifth is dropped.
    run_rec(64'h1F, 64'h0, 45);
    verify("overflow", 64'h0000_000F_F7FB_FDFE, 64'h0000_0010_0804_0200, 64'h0000_001F_FFFF_FFFE);
    check("overflow_rise",       ovf_v  & 64'h3F, 64'h20);
    check("overflow_model_rise", movf_v & 64'h3F, 64'h20);
    cycle_in(1'b0, 1'b1);
    check("overflow_cleared", 64'({ps.Overflow, ps.Busy}), 64'h0);
    repeat (3) cycle_in(1'b0, 1'b0);

    // Shot on the final gap cycle with an empty queue.
    run_rec(64'h201, 64'h0, 30);
    verify("final_gap", 64'h3FDFE, 64'h40200, 64'h7FFFE);
    settle();

    // Abort with two queued strobes; Clear wins over a simultaneous Shot.
    run_rec(64'h17, 64'h10, 20);
    verify("abort", 64'h1E, 64'h0, 64'h1E);
    check("abort_ovf", ovf_v, 64'h0);
    settle();

    // Shot at 0 and 5: retriggers or queues depending on the build.
    run_rec(64'h21, 64'h0, 30);
    if (RETRIG) verify("second_in_hold", 64'h3FFE, 64'h4000, 64'h7FFE);
    else        verify("second_in_hold", 64'h3FDFE, 64'h40200, 64'h7FFFE);
    settle();

    // Asynchronous reset in the middle of a level.
    cycle_in(1'b1, 1'b0);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b0, 1'b0);
    check("pre_reset_level", 64'(ps.Level), 64'h1);
    #1 reset = 1'b0;
    #1 check("async_reset_outputs", 64'({ps.Level, ps.Busy, ps.Done, ps.Overflow}), 64'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) cycle_in(1'b0, 1'b0);

    // Random traffic at several strobe densities.
    for (int b = 0; b < 6; b++) begin
      case (b % 4)
        0: dens = 5;
        1: dens = 20;
        2: dens = 50;
        default: dens = 90;
      endcase
      for (int i = 0; i < 500; i++)
        cycle_in($urandom_range(0, 99) < dens, $urandom_range(0, 255) == 0);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
